triangle_raster: RTL and testbench
==================================

TRIANGLE_RASTER -- requirements
Module: triangle

Interface
REQ-001 The block SHALL have no parameters; coordinate width is fixed at 3 bits (8x8 grid).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 nt  input  1  new-triangle strobe, high for the one cycle that carries vertex 1.
REQ-005 xi  input  3  vertex x coordinate, sampled on rising edge.
REQ-006 yi  input  3  vertex y coordinate, sampled on rising edge.
REQ-007 busy  output  1  high while the block cannot accept nt.
REQ-008 po  output  1  high when xo/yo carry a valid rendered point.
REQ-009 xo  output  3  rendered point x.
REQ-010 yo  output  3  rendered point y.

Function
REQ-011 States SHALL be IDLE, GET2, GET3, RENDER.
REQ-012 IDLE: nt=1 at an edge SHALL capture (x1,y1) from xi/yi and move to GET2; nt is ignored outside IDLE.
REQ-013 GET2 SHALL capture (x2,y2) on the next edge; GET3 SHALL capture (x3,y3) on the following edge, set busy=1 and enter RENDER.
REQ-014 Valid input: x1==x2, y1<y2, y1<=y3<=y2, x3>x1; behaviour for invalid input is unspecified unless TRI_INPUT_CHECK_EN is defined.
REQ-015 Point (x,y) is inside for y<=y3 iff (x-x1)*(y3-y1) <= (x3-x1)*(y-y1); for y>y3 iff (x-x1)*(y2-y3) <= (x3-x1)*(y2-y); edges and vertices count as inside.
REQ-016 Products SHALL use unsigned 6-bit operands (max 49); differences are non-negative for valid input.
REQ-017 Scan order: rows y=y1..y2 ascending; within a row x=x1 ascending while inside; exactly one point per cycle, no idle cycles between points or rows.
REQ-018 First point (x1,y1) SHALL appear with po=1 in the cycle after the GET3 capture edge.
REQ-019 Next point: (x+1,y) if inside, else (x1,y+1); after the last inside point of row y2, rendering ends.
REQ-020 On the edge after the last point, po and busy SHALL both go to 0 and state SHALL return to IDLE; nt SHALL be accepted in that same IDLE cycle.
REQ-021 xo/yo SHALL hold their last value when po=0.

Reset
REQ-022 reset=0 SHALL asynchronously force state IDLE, busy=0, po=0, xo=0, yo=0 and clear stored vertices.
REQ-023 Reset mid-render SHALL abandon the triangle; no further po until a new full triangle is loaded.

Configuration
REQ-024 With TRI_INPUT_CHECK_EN defined, a triangle violating REQ-014 SHALL produce no po pulses; busy SHALL be high for exactly one cycle after the GET3 capture, then IDLE.
REQ-025 Without TRI_INPUT_CHECK_EN, no check logic SHALL exist and REQ-015..REQ-019 apply unconditionally.

Structure
REQ-026 Package triangle_pkg SHALL hold the coordinate width constant (3), the state enum and the coordinate typedef.
REQ-027 One sub-module, triangle_inside_test, SHALL implement the combinational REQ-015 test for a candidate point.

Verification
REQ-028 (0,0),(0,4),(4,2) -> 13 points: 00;00,10,20;00..40 at y2;00,10,20 at y3;04 -> rows sizes 1,3,5,3,1, po contiguous 13 cycles.
REQ-029 (1,0),(1,6),(5,3) -> 17 points, row sizes 1,2,3,5,3,2,1, x starting at 1 each row.
REQ-030 (0,0),(0,2),(2,2) (y3==y2) -> 6 points: (0,0),(0,1),(1,1),(0,2),(1,2),(2,2).
REQ-031 Back-to-back: nt issued the cycle busy falls after REQ-028 -> REQ-029 output follows with no lost or extra points; nt asserted while busy=1 is ignored.
REQ-032 reset=0 during RENDER of REQ-028 -> po/busy drop immediately, xo=yo=0; subsequent REQ-030 triangle renders correctly.
REQ-033 With TRI_INPUT_CHECK_EN: (0,0),(1,4),(4,2) -> zero po pulses, busy high one cycle.

Source files
------------

// File: rtl/triangle_pkg.sv
// rtl/triangle_pkg.sv - shared constants and types for the triangle rasterizer
// Holds the coordinate width, the coordinate type and the FSM state encoding.
package triangle_pkg;

    localparam int COORD_W = 3;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GET2   = 2'd1,
        ST_GET3   = 2'd2,
        ST_RENDER = 2'd3
    } state_t;

endpackage

// File: rtl/triangle_inside_test.sv
// rtl/triangle_inside_test.sv - combinational inside test for one candidate point
// Ports:
//   x_i      candidate x, one bit wider than a coordinate so x+1 past 7 is representable
//   y_i      candidate y
//   x1_i/y1_i, y2_i, x3_i/y3_i  stored vertices (x2 == x1 for a valid triangle)
//   inside_o 1 when the candidate lies inside or on the triangle
module triangle_inside_test
    import triangle_pkg::*;
(
    input  logic [COORD_W:0]   x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] x1_i,
    input  logic [COORD_W-1:0] y1_i,
    input  logic [COORD_W-1:0] y2_i,
    input  logic [COORD_W-1:0] x3_i,
    input  logic [COORD_W-1:0] y3_i,
    output logic               inside_o
);
    localparam int OP_W = 2 * COORD_W;

    logic [OP_W-1:0]   dx;
    logic [OP_W-1:0]   dx3;
    logic [OP_W-1:0]   dy_edge;
    logic [OP_W-1:0]   dy_pt;
    logic [2*OP_W-1:0] lhs;
    logic [2*OP_W-1:0] rhs;

    always_comb begin
        dx  = OP_W'(x_i) - OP_W'(x1_i);
        dx3 = OP_W'(x3_i) - OP_W'(x1_i);
        // Upper half is bounded by edge v1-v3, lower half by edge v3-v2.
        if (y_i <= y3_i) begin
            dy_edge = OP_W'(y3_i) - OP_W'(y1_i);
            dy_pt   = OP_W'(y_i) - OP_W'(y1_i);
        end else begin
            dy_edge = OP_W'(y2_i) - OP_W'(y3_i);
            dy_pt   = OP_W'(y2_i) - OP_W'(y_i);
        end
        lhs = (2*OP_W)'(dx) * (2*OP_W)'(dy_edge);
        rhs = (2*OP_W)'(dx3) * (2*OP_W)'(dy_pt);
        // The triangle never extends right of x3; the explicit bound matters
        // when y3 == y1, where the edge inequality degenerates to 0 <= 0.
        inside_o = (lhs <= rhs) && (x_i <= (COORD_W+1)'(x3_i));
    end

endmodule

// File: rtl/triangle_raster.sv
// rtl/triangle_raster.sv - rasterizes a flat-left triangle on an 8x8 grid, one point per cycle
// Optional feature: define TRI_INPUT_CHECK_EN to reject triangles with invalid vertex ordering.
// Ports:
//   clk     clock, rising edge
//   reset   asynchronous active-low reset
//   nt      new-triangle strobe, carries vertex 1 (accepted only in IDLE)
//   xi/yi   vertex coordinates, vertex 1/2/3 on consecutive cycles
//   busy    high while rendering
//   po      xo/yo carry a valid point
//   xo/yo   rendered point, held when po is low
module triangle_raster
    import triangle_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               nt,
    input  logic [COORD_W-1:0] xi,
    input  logic [COORD_W-1:0] yi,
    output logic               busy,
    output logic               po,
    output logic [COORD_W-1:0] xo,
    output logic [COORD_W-1:0] yo
);
    state_t         state_q;
    coord_t         x1_q;
    coord_t         y1_q;
    coord_t         y2_q;
    coord_t         x3_q;
    coord_t         y3_q;
    logic           busy_q;
    logic           po_q;
    coord_t         xo_q;
    coord_t         yo_q;
    logic [COORD_W:0] cand_x;
    logic           next_inside;

`ifdef TRI_INPUT_CHECK_EN
    coord_t x2_q;
    logic   tri_valid;

    // Vertex 3 is still on xi/yi during the GET3 cycle.
    assign tri_valid = (x1_q == x2_q) && (y1_q < y2_q) &&
                       (y1_q <= yi) && (yi <= y2_q) && (xi > x1_q);
`endif

    // Candidate is the point to the right of the one currently on the outputs.
    assign cand_x = {1'b0, xo_q} + (COORD_W+1)'(1);

    triangle_inside_test u_inside (
        .x_i      (cand_x),
        .y_i      (yo_q),
        .x1_i     (x1_q),
        .y1_i     (y1_q),
        .y2_i     (y2_q),
        .x3_i     (x3_q),
        .y3_i     (y3_q),
        .inside_o (next_inside)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x1_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            x3_q    <= '0;
            y3_q    <= '0;
            busy_q  <= 1'b0;
            po_q    <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
`ifdef TRI_INPUT_CHECK_EN
            x2_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (nt) begin
                        x1_q    <= xi;
                        y1_q    <= yi;
                        state_q <= ST_GET2;
                    end
                end
                ST_GET2: begin
                    y2_q    <= yi;
`ifdef TRI_INPUT_CHECK_EN
                    x2_q    <= xi;
`endif
                    state_q <= ST_GET3;
                end
                ST_GET3: begin
                    x3_q    <= xi;
                    y3_q    <= yi;
                    busy_q  <= 1'b1;
                    state_q <= ST_RENDER;
`ifdef TRI_INPUT_CHECK_EN
                    // A rejected triangle enters RENDER with po low and
                    // leaves on the next edge.
                    po_q    <= tri_valid;
                    if (tri_valid) begin
                        xo_q <= x1_q;
                        yo_q <= y1_q;
                    end
`else
                    // Vertex 1 is always inside, so it is emitted immediately.
                    po_q    <= 1'b1;
                    xo_q    <= x1_q;
                    yo_q    <= y1_q;
`endif
                end
                ST_RENDER: begin
`ifdef TRI_INPUT_CHECK_EN
                    if (!po_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else
`endif
                    if (next_inside) begin
                        xo_q <= cand_x[COORD_W-1:0];
                    end else if (yo_q == y2_q) begin
                        po_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        xo_q <= x1_q;
                        yo_q <= yo_q + COORD_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign po   = po_q;
    assign xo   = xo_q;
    assign yo   = yo_q;

endmodule

// File: tb/tb_triangle_raster.sv
// tb/tb_triangle_raster.sv - self-checking bench for triangle_raster
module tb_triangle_raster;

    logic       clk;
    logic       reset;
    logic       nt;
    logic [2:0] xi;
    logic [2:0] yi;
    logic       busy;
    logic       po;
    logic [2:0] xo;
    logic [2:0] yo;

    int n_checks = 0;
    int n_fail   = 0;

    int gx[$];
    int gy[$];
    int mx[$];
    int my[$];

    typedef struct {
        int x1, y1, x2, y2, x3, y3;
        int exp_count;
        int last_x, last_y;
    } vec_t;

    vec_t vecs[6];

    triangle_raster dut (
        .clk   (clk),
        .reset (reset),
        .nt    (nt),
        .xi    (xi),
        .yi    (yi),
        .busy  (busy),
        .po    (po),
        .xo    (xo),
        .yo    (yo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: every grid point that satisfies the triangle inequalities,
    // listed row by row, left to right.
    task automatic build_model(input int x1, input int y1, input int y2,
                               input int x3, input int y3);
        mx.delete();
        my.delete();
        for (int y = y1; y <= y2; y++) begin
            for (int x = x1; x <= x3; x++) begin
                bit in;
                if (y <= y3)
                    in = ((x - x1) * (y3 - y1)) <= ((x3 - x1) * (y - y1));
                else
                    in = ((x - x1) * (y2 - y3)) <= ((x3 - x1) * (y2 - y));
                if (in) begin
                    mx.push_back(x);
                    my.push_back(y);
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the first render cycle.
    task automatic load_tri(input int x1, input int y1, input int x2, input int y2,
                            input int x3, input int y3);
        nt = 1'b1;
        xi = 3'(x1);
        yi = 3'(y1);
        @(negedge clk);
        nt = 1'b0;
        xi = 3'(x2);
        yi = 3'(y2);
        @(negedge clk);
        xi = 3'(x3);
        yi = 3'(y3);
        @(negedge clk);
    endtask

    // Records points while po is high; with noise, keeps nt high with junk
    // coordinates which must be ignored while busy.
    task automatic collect(input bit noise);
        int cyc = 0;
        gx.delete();
        gy.delete();
        check(po === 1'b1, "first_point_po", int'(po), 1);
        while (po === 1'b1 && cyc < 100) begin
            check(busy === 1'b1, "busy_while_po", int'(busy), 1);
            gx.push_back(int'(xo));
            gy.push_back(int'(yo));
            if (noise) begin
                nt = 1'b1;
                xi = 3'($urandom_range(7, 0));
                yi = 3'($urandom_range(7, 0));
            end
            @(negedge clk);
            cyc++;
        end
        nt = 1'b0;
        check(cyc < 100, "render_timeout", cyc, 100);
        check(busy === 1'b0, "busy_after_render", int'(busy), 0);
    endtask

    task automatic compare_model(input string tag);
        check(gx.size() == mx.size(), {tag, "_count_vs_model"}, gx.size(), mx.size());
        for (int i = 0; i < gx.size() && i < mx.size(); i++)
            check(gx[i] == mx[i] && gy[i] == my[i], {tag, "_point_xy"},
                  gx[i] * 10 + gy[i], mx[i] * 10 + my[i]);
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 4, 4, 2, 13, 0, 4};
        vecs[1] = '{1, 0, 1, 6, 5, 3, 17, 1, 6};
        vecs[2] = '{0, 0, 0, 2, 2, 2,  6, 2, 2};
        vecs[3] = '{0, 0, 0, 7, 7, 7, 36, 7, 7};
        vecs[4] = '{3, 3, 3, 4, 4, 4,  3, 4, 4};
        vecs[5] = '{2, 1, 2, 5, 6, 1, 15, 2, 5};

        reset = 1'b0;
        nt    = 1'b0;
        xi    = '0;
        yi    = '0;
        @(negedge clk);
        @(negedge clk);
        check(busy === 1'b0, "reset_busy", int'(busy), 0);
        check(po === 1'b0, "reset_po", int'(po), 0);
        check(xo === 3'd0, "reset_xo", int'(xo), 0);
        check(yo === 3'd0, "reset_yo", int'(yo), 0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven triangles, including y3==y2, y3==y1 and full-grid cases.
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            load_tri(vecs[t].x1, vecs[t].y1, vecs[t].x2, vecs[t].y2, vecs[t].x3, vecs[t].y3);
            collect(1'b0);
            check(gx.size() == vecs[t].exp_count, "table_count", gx.size(), vecs[t].exp_count);
            if (gx.size() > 0)
                check(gx[gx.size()-1] == vecs[t].last_x && gy[gy.size()-1] == vecs[t].last_y,
                      "table_last_point", gx[gx.size()-1] * 10 + gy[gy.size()-1],
                      vecs[t].last_x * 10 + vecs[t].last_y);
            build_model(vecs[t].x1, vecs[t].y1, vecs[t].y2, vecs[t].x3, vecs[t].y3);
            compare_model("table");
        end

        // Back-to-back: nt with noise during render, next triangle in the IDLE cycle.
        @(negedge clk);
        load_tri(0, 0, 0, 4, 4, 2);
        collect(1'b1);
        build_model(0, 0, 4, 4, 2);
        compare_model("b2b_first");
        load_tri(1, 0, 1, 6, 5, 3);
        collect(1'b0);
        build_model(1, 0, 6, 5, 3);
        compare_model("b2b_second");

        // Reset in the middle of a render.
        @(negedge clk);
        load_tri(0, 0, 0, 4, 4, 2);
        repeat (4) @(negedge clk);
        check(po === 1'b1, "pre_reset_po", int'(po), 1);
        #2 reset = 1'b0;
        #1;
        check(po === 1'b0, "midreset_po", int'(po), 0);
        check(busy === 1'b0, "midreset_busy", int'(busy), 0);
        check(xo === 3'd0, "midreset_xo", int'(xo), 0);
        check(yo === 3'd0, "midreset_yo", int'(yo), 0);
        @(negedge clk);
        reset = 1'b1;
        begin
            int stray = 0;
            repeat (6) begin
                @(negedge clk);
                if (po !== 1'b0) stray++;
            end
            check(stray == 0, "no_po_after_reset", stray, 0);
        end
        load_tri(0, 0, 0, 2, 2, 2);
        collect(1'b0);
        build_model(0, 0, 2, 2, 2);
        compare_model("post_reset");

`ifdef TRI_INPUT_CHECK_EN
        // Invalid triangle: x2 != x1.
        @(negedge clk);
        load_tri(0, 0, 1, 4, 4, 2);
        check(po === 1'b0, "invalid_po", int'(po), 0);
        check(busy === 1'b1, "invalid_busy_one", int'(busy), 1);
        @(negedge clk);
        check(busy === 1'b0, "invalid_busy_drop", int'(busy), 0);
        begin
            int stray = 0;
            repeat (4) begin
                if (po !== 1'b0) stray++;
                @(negedge clk);
            end
            check(stray == 0, "invalid_no_po", stray, 0);
        end
`endif

        // Random valid triangles against the reference model.
        for (int r = 0; r < 40; r++) begin
            int x1, y1, y2, x3, y3;
            x1 = $urandom_range(6, 0);
            x3 = $urandom_range(7, x1 + 1);
            y1 = $urandom_range(6, 0);
            y2 = $urandom_range(7, y1 + 1);
            y3 = $urandom_range(y2, y1);
            @(negedge clk);
            load_tri(x1, y1, x1, y2, x3, y3);
            collect(1'b0);
            build_model(x1, y1, y2, x3, y3);
            compare_model("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
